vga_scan_engine: RTL

//   Pixel-scan end of the colour interface: generates 640x480@60 VGA timing from clk_50MHz,

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 42 ++++
 rtl/vga_scan_engine.sv | 118 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480@60 VGA timing defaults and colour field layout
// shared by the scan engine and its axis counters.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic SYNC_POL = 1'b0;

    localparam int R_HI = 7;
    localparam int R_LO = 5;
    localparam int G_HI = 4;
    localparam int G_LO = 2;
    localparam int B_HI = 1;
    localparam int B_LO = 0;

endpackage

// File: rtl/vga_axis_counter.sv
// One scan axis: position counter with blanking and sync decode
// of the position being entered on this clock.
module vga_axis_counter #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48
) (
    input  logic       clk_50MHz,
    input  logic       RESET,
    input  logic       en,
    output logic [9:0] count,
    output logic       blank,
    output logic       sync,
    output logic       wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [9:0] LAST = 10'(TOTAL - 1);
    localparam logic [9:0] ACT  = 10'(ACTIVE);
    localparam logic [9:0] S_LO = 10'(ACTIVE + FP);
    localparam logic [9:0] S_HI = 10'(ACTIVE + FP + SYNC - 1);

    logic [9:0] nxt;

    assign wrap = en && (count == LAST);

    always_comb begin
        nxt = count;
        if (en) nxt = (count == LAST) ? '0 : count + 10'd1;
    end

    // decoded from nxt so the caller can register it with the new position
    assign blank = (nxt >= ACT);
    assign sync  = (nxt >= S_LO) && (nxt <= S_HI);

    always_ff @(posedge clk_50MHz) begin
        if (RESET) count <= '0;
        else       count <= nxt;
    end

endmodule

// File: rtl/vga_scan_engine.sv
// VGA scan engine: pixel clock, scan coordinates for the colour
// producer, and a one-pixel colour/sync pipeline to the DAC pins.
module vga_scan_engine #(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FP     = vga_timing_pkg::H_FP,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BP     = vga_timing_pkg::H_BP,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FP     = vga_timing_pkg::V_FP,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BP     = vga_timing_pkg::V_BP,
    parameter logic SYNC_POL = vga_timing_pkg::SYNC_POL
) (
    input  logic       clk_50MHz,
    input  logic       RESET,
    input  logic [7:0] COLOR,
    output logic       CLK_DATA,
    output logic [9:0] CURX,
    output logic [8:0] CURY,
    output logic       HBLANK,
    output logic       VBLANK,
    output logic       FRAME_START,
    output logic       hs_vga,
    output logic       vs_vga,
    output logic [2:0] RED,
    output logic [2:0] GREEN,
    output logic [1:0] BLUE
);

    import vga_timing_pkg::R_HI, vga_timing_pkg::R_LO;
    import vga_timing_pkg::G_HI, vga_timing_pkg::G_LO;
    import vga_timing_pkg::B_HI, vga_timing_pkg::B_LO;

    logic       phase;
    logic       adv;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hb, hs, hwrap;
    logic       vb, vs, vwrap;
    logic       hs_d, vs_d;

    // advance on the edge where CLK_DATA falls
    assign adv = !phase;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h (
        .clk_50MHz (clk_50MHz),
        .RESET     (RESET),
        .en        (adv),
        .count     (hcount),
        .blank     (hb),
        .sync      (hs),
        .wrap      (hwrap)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v (
        .clk_50MHz (clk_50MHz),
        .RESET     (RESET),
        .en        (hwrap && adv),
        .count     (vcount),
        .blank     (vb),
        .sync      (vs),
        .wrap      (vwrap)
    );

    always_ff @(posedge clk_50MHz) begin
        if (RESET) begin
            phase       <= 1'b0;
            CLK_DATA    <= 1'b0;
            FRAME_START <= 1'b0;
            HBLANK      <= 1'b1;
            VBLANK      <= 1'b1;
            CURX        <= '0;
            CURY        <= '0;
            hs_d        <= 1'b0;
            vs_d        <= 1'b0;
            hs_vga      <= !SYNC_POL;
            vs_vga      <= !SYNC_POL;
            RED         <= '0;
            GREEN       <= '0;
            BLUE        <= '0;
        end else begin
            phase       <= !phase;
            CLK_DATA    <= phase;
            FRAME_START <= vwrap;
            if (adv) begin
                HBLANK <= hb;
                VBLANK <= vb;
                CURX   <= (hb || vb || hwrap) ? '0 : hcount + 10'd1;
                CURY   <= (vb || vwrap) ? '0 : 9'(vcount + 10'(hwrap));
                hs_d   <= hs;
                vs_d   <= vs;
                hs_vga <= hs_d ? SYNC_POL : !SYNC_POL;
                vs_vga <= vs_d ? SYNC_POL : !SYNC_POL;
                // COLOR answers the coordinate still shown on CURX/CURY
                if (HBLANK || VBLANK) begin
                    RED   <= '0;
                    GREEN <= '0;
                    BLUE  <= '0;
                end else begin
                    RED   <= COLOR[R_HI:R_LO];
                    GREEN <= COLOR[G_HI:G_LO];
                    BLUE  <= COLOR[B_HI:B_LO];
                end
            end
        end
    end

endmodule
